uart_rx_top: RTL and testbench
==============================

Name: uart_rx_top

Overview:
- Oversampling UART receiver; converts serial `rx_in` into a parallel byte.
- Frame: 1 start bit (0), DATA_WIDTH data bits LSB-first, optional parity bit, 1 stop bit (1).
- Runs on a fast system clock; one UART bit period = prescale+1 clock cycles (supported ratios 8/16/32).
- Reports start-glitch, parity and stop errors; pulses `data_valid` with the byte on a good frame.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- PRESCALE_W, 5, width of the `prescale` input.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- rx_in  in  1  serial line; idle high.
- par_en  in  1  1 = frame carries a parity bit.
- par_typ  in  1  0 = even parity (bit = XOR of data), 1 = odd parity (bit = XNOR of data).
- prescale  in  PRESCALE_W  oversampling count minus 1; legal values 7, 15, 31.
- p_data  out  DATA_WIDTH  received byte; valid while `data_valid`=1.
- data_valid  out  1  one-cycle pulse, good frame received.
- strt_glitch  out  1  one-cycle pulse, start bit rejected.
- par_err  out  1  one-cycle pulse, parity mismatch.
- stp_err  out  1  one-cycle pulse, stop bit sampled 0.

Behaviour:
- Reset (rst=1 at clk edge): FSM to IDLE; edge_cnt and bit_cnt to 0; p_data to 0; data_valid, strt_glitch, par_err and stp_err to 0. Reset dominates `rx_in`.
- `par_en`, `par_typ` and `prescale` are sampled only in IDLE; they are stable for a whole frame.
- edge_cnt counts 0..prescale within a bit period, then wraps to 0 and increments bit_cnt.
- Sampler takes `rx_in` at edge_cnt = H-1, H, H+1, where H = (prescale+1)/2.
- Sampled bit = majority of the three samples; it is valid from edge H+2 onward.
- FSM states: IDLE, START, DATA, PARITY, STOP, OUT.
- IDLE: `rx_in`=1 keeps IDLE, with no outputs and no counting. `rx_in`=0 goes to START with edge_cnt=0 next cycle.
- START: at edge_cnt=prescale, sampled bit 1 pulses `strt_glitch` for 1 cycle and returns to IDLE. Sampled bit 0 goes to DATA.
- DATA: at each edge_cnt=prescale, the sampled bit is shifted into p_data position bit_cnt (LSB first). After DATA_WIDTH bits, go to PARITY if par_en=1, else STOP.
- PARITY: expected bit = par_typ ? ~^data : ^data. At edge_cnt=prescale, a mismatch pulses `par_err` for 1 cycle and returns to IDLE (byte discarded). A match goes to STOP.
- STOP: at edge_cnt=prescale, sampled 0 pulses `stp_err` for 1 cycle and returns to IDLE. Sampled 1 goes to OUT.
- OUT (1 cycle): `data_valid`=1 and `p_data` = received byte. Next state is START if `rx_in`=0 (back-to-back frame), else IDLE.
- `p_data` holds its last value until the next good frame completes; it is updated only on OUT entry.
- Error flags are mutually exclusive; at most one flag or `data_valid` is high in any cycle.
- A line returning high mid-frame is not aborted; the frame completes on its sampled values.
- Illegal prescale values give undefined bit timing; no protection is required.

Optional Feature:
- Macro UART_RX_SYNC_EN.
- Defined: `rx_in` passes through a 2-flop synchronizer (reset value 1) before the FSM and sampler. Every event timing above shifts by +2 cycles.
- Undefined: `rx_in` feeds the FSM and sampler directly. The timing in Behaviour is exact.

Test Plan:
- Reset and idle: rst=1 with rx_in=0 for 5 cycles, then rst=0 with rx_in=1 for all prescale ∈ {7,15,31} and all par_en/par_typ combinations → all outputs stay 0.
- Start glitch: rx_in=0 for 1 cycle, then 1, for prescale ∈ {7,15,31} → strt_glitch=1 exactly prescale cycles later for 1 cycle; no data_valid.
- Parity error: par_en=1, par_typ ∈ {0,1}, data 0x00..0xFF, inverted parity bit → par_err pulses at end of the parity bit; data_valid stays 0.
- Stop error: all four par_en/par_typ combos, correct parity, stop bit=0 → stp_err pulses at end of the stop bit (bit 9 without parity, bit 10 with parity).
- Good frame: all combos, data 0x00..0xFF (e.g. 0xA5 with par_typ=0 → parity 0), random 0–7 idle cycles between frames → data_valid=1 for 1 cycle after the stop bit and p_data=data.
- Back-to-back: two good frames 0x3C then 0xC3 with no idle gap → two data_valid pulses with p_data 0x3C then 0xC3.

Source files
------------

// File: rtl/uart_rx_if.sv
// Handshake bundle between a UART line/config driver and the oversampling receiver.
interface uart_rx_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE_W = 5
);
  logic                  rx_in;
  logic                  par_en;
  logic                  par_typ;
  logic [PRESCALE_W-1:0] prescale;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  strt_glitch;
  logic                  par_err;
  logic                  stp_err;

  modport master (
    output rx_in, par_en, par_typ, prescale,
    input  p_data, data_valid, strt_glitch, par_err, stp_err
  );

  modport slave (
    input  rx_in, par_en, par_typ, prescale,
    output p_data, data_valid, strt_glitch, par_err, stp_err
  );
endinterface

// File: rtl/uart_rx_top.sv
// Oversampling UART receiver: start, DATA_WIDTH data bits LSB-first, optional parity, stop.
// Optional 2-flop input synchronizer enabled by defining UART_RX_SYNC_EN.
module uart_rx_top #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE_W = 5
) (
  input logic     clk,
  input logic     rst,
  uart_rx_if.slave uart
);

  localparam int unsigned BitCntW = $clog2(DATA_WIDTH + 1);
  localparam logic [PRESCALE_W:0] ExtOne = (PRESCALE_W + 1)'(1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StOut} state_e;

  state_e                state_q, state_d;
  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic [2:0]            samp_q;
  logic                  par_en_q, par_typ_q;
  logic [PRESCALE_W-1:0] prescale_q;

  logic                  rx;
  logic [PRESCALE_W:0]   half, cnt_ext;
  logic                  bit_smp, bit_end, par_exp;
  logic                  data_valid, strt_glitch, par_err, stp_err;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], uart.rx_in};
    end
  end
  assign rx = sync_q[1];
`else
  assign rx = uart.rx_in;
`endif

  assign half    = ({1'b0, prescale_q} + ExtOne) >> 1;
  assign cnt_ext = {1'b0, edge_cnt_q};
  assign bit_smp = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
  assign bit_end = (edge_cnt_q == prescale_q);
  assign par_exp = par_typ_q ? ~^data_q : ^data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      data_q     <= '0;
      p_data_q   <= '0;
      samp_q     <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      prescale_q <= '0;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      p_data_q   <= p_data_d;
      // Config is frozen for the whole frame once we leave idle
      if (state_q == StIdle) begin
        par_en_q   <= uart.par_en;
        par_typ_q  <= uart.par_typ;
        prescale_q <= uart.prescale;
      end
      if (state_q != StIdle) begin
        if (cnt_ext == half - ExtOne) samp_q[0] <= rx;
        if (cnt_ext == half)          samp_q[1] <= rx;
        if (cnt_ext == half + ExtOne) samp_q[2] <= rx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    edge_cnt_d  = edge_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    data_d      = data_q;
    p_data_d    = p_data_q;
    data_valid  = 1'b0;
    strt_glitch = 1'b0;
    par_err     = 1'b0;
    stp_err     = 1'b0;

    if (state_q != StIdle && state_q != StOut) begin
      edge_cnt_d = bit_end ? '0 : edge_cnt_q + PRESCALE_W'(1);
    end

    unique case (state_q)
      StIdle: begin
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
        if (!rx) state_d = StStart;
      end
      StStart: begin
        if (bit_end) begin
          if (bit_smp) begin
            strt_glitch = 1'b1;
            state_d     = StIdle;
          end else begin
            bit_cnt_d = '0;
            state_d   = StData;
          end
        end
      end
      StData: begin
        if (bit_end) begin
          // Shift right so the first received bit lands in the LSB after DATA_WIDTH bits
          data_d = {bit_smp, data_q[DATA_WIDTH-1:1]};
          if (bit_cnt_q == BitCntW'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? StParity : StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + BitCntW'(1);
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          if (bit_smp != par_exp) begin
            par_err = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StStop;
          end
        end
      end
      StStop: begin
        if (bit_end) begin
          if (!bit_smp) begin
            stp_err = 1'b1;
            state_d = StIdle;
          end else begin
            p_data_d = data_q;
            state_d  = StOut;
          end
        end
      end
      StOut: begin
        data_valid = 1'b1;
        edge_cnt_d = '0;
        state_d    = rx ? StIdle : StStart;
      end
      default: state_d = StIdle;
    endcase
  end

  assign uart.p_data      = p_data_q;
  assign uart.data_valid  = data_valid;
  assign uart.strt_glitch = strt_glitch;
  assign uart.par_err     = par_err;
  assign uart.stp_err     = stp_err;

endmodule

// File: tb/tb_uart_rx_top.sv
// Directed self-checking bench for uart_rx_top: event log checked for kind, cycle and byte.
module tb_uart_rx_top;

`ifdef UART_RX_SYNC_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 0;
`endif

  localparam int KDv = 0, KGl = 1, KPe = 2, KSe = 3, KMulti = 9;

  typedef struct {
    int         kind;
    int         cyc;
    logic [7:0] data;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    bit         pe;
    bit         pt;
    int         ps;
    bit         bad_par;
    bit         bad_stop;
    int         gap;
  } frm_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  ev_t  evq[$];
  logic [7:0] last_good = 8'h00;

  uart_rx_if #(.DATA_WIDTH(8), .PRESCALE_W(5)) u_if ();

  uart_rx_top #(.DATA_WIDTH(8), .PRESCALE_W(5)) dut (
    .clk  (clk),
    .rst  (rst),
    .uart (u_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Log every output pulse with the cycle it was seen in
  always @(negedge clk) begin
    int nhi;
    nhi = int'(u_if.data_valid) + int'(u_if.strt_glitch) + int'(u_if.par_err) + int'(u_if.stp_err);
    if (nhi > 1) evq.push_back('{KMulti, cyc, u_if.p_data});
    else if (u_if.data_valid)  evq.push_back('{KDv, cyc, u_if.p_data});
    else if (u_if.strt_glitch) evq.push_back('{KGl, cyc, u_if.p_data});
    else if (u_if.par_err)     evq.push_back('{KPe, cyc, u_if.p_data});
    else if (u_if.stp_err)     evq.push_back('{KSe, cyc, u_if.p_data});
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic send_bit(input logic v, input int ps);
    u_if.rx_in = v;
    repeat (ps + 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit pe, input bit pt, input int ps,
                            input bit bad_par, input bit bad_stop);
    logic par;
    par = pt ? ~^d : ^d;
    send_bit(1'b0, ps);
    for (int i = 0; i < 8; i++) send_bit(d[i], ps);
    if (pe) send_bit(par ^ bad_par, ps);
    send_bit(~bad_stop, ps);
    u_if.rx_in = 1'b1;
  endtask

  task automatic run_frame(input frm_t f);
    int c0, p, exp_kind, exp_cyc;
    string tag;
    repeat (f.gap + 1) @(negedge clk);
    u_if.par_en   = f.pe;
    u_if.par_typ  = f.pt;
    u_if.prescale = 5'(f.ps);
    @(negedge clk);
    evq.delete();
    p  = f.ps + 1;
    c0 = cyc + 1;
    send_frame(f.data, f.pe, f.pt, f.ps, f.bad_par, f.bad_stop);
    repeat (2 * p + 4) @(negedge clk);
    if (f.bad_par) begin
      exp_kind = KPe;
      exp_cyc  = c0 + 9 * p + f.ps + Lat;
    end else if (f.bad_stop) begin
      exp_kind = KSe;
      exp_cyc  = c0 + (f.pe ? 10 : 9) * p + f.ps + Lat;
    end else begin
      exp_kind = KDv;
      exp_cyc  = c0 + (f.pe ? 11 : 10) * p + Lat;
    end
    tag = $sformatf("d%02h_pe%0d_pt%0d_ps%0d", f.data, f.pe, f.pt, f.ps);
    check({tag, "_nev"}, evq.size(), 1);
    if (evq.size() >= 1) begin
      check({tag, "_kind"}, evq[0].kind, exp_kind);
      check({tag, "_cyc"}, evq[0].cyc, exp_cyc);
      if (exp_kind == KDv) begin
        check({tag, "_data"}, evq[0].data, f.data);
        last_good = f.data;
      end
    end
    check({tag, "_hold"}, u_if.p_data, last_good);
  endtask

  frm_t frames[$] = '{
    '{8'hA5, 1'b0, 1'b0, 15, 1'b0, 1'b0, 0},
    '{8'hA5, 1'b1, 1'b0, 15, 1'b0, 1'b0, 3},
    '{8'hA5, 1'b1, 1'b1,  7, 1'b0, 1'b0, 7},
    '{8'h00, 1'b1, 1'b1, 31, 1'b0, 1'b0, 1},
    '{8'hFF, 1'b1, 1'b0,  7, 1'b0, 1'b0, 5},
    '{8'h3C, 1'b0, 1'b1, 31, 1'b0, 1'b0, 2},
    '{8'h00, 1'b1, 1'b0, 15, 1'b1, 1'b0, 4},
    '{8'hFF, 1'b1, 1'b1,  7, 1'b1, 1'b0, 0},
    '{8'h81, 1'b1, 1'b0, 31, 1'b1, 1'b0, 6},
    '{8'h12, 1'b0, 1'b0, 15, 1'b0, 1'b1, 2},
    '{8'h34, 1'b0, 1'b1,  7, 1'b0, 1'b1, 1},
    '{8'h56, 1'b1, 1'b0, 31, 1'b0, 1'b1, 3},
    '{8'h78, 1'b1, 1'b1, 15, 1'b0, 1'b1, 0},
    '{8'h5A, 1'b0, 1'b0,  7, 1'b0, 1'b0, 7}
  };

  initial begin
    int c0, p;
    int pss[3] = '{7, 15, 31};
    u_if.rx_in    = 1'b0;
    u_if.par_en   = 1'b0;
    u_if.par_typ  = 1'b0;
    u_if.prescale = 5'd15;

    // Reset dominates a low line
    repeat (5) @(negedge clk);
    check("rst_pdata", u_if.p_data, 8'h00);
    check("rst_dv", u_if.data_valid, 1'b0);
    check("rst_glitch", u_if.strt_glitch, 1'b0);
    check("rst_perr", u_if.par_err, 1'b0);
    check("rst_serr", u_if.stp_err, 1'b0);
    rst = 1'b0;
    u_if.rx_in = 1'b1;
    evq.delete();
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < 4; c++) begin
        u_if.prescale = 5'(pss[i]);
        u_if.par_en   = c[1];
        u_if.par_typ  = c[0];
        repeat (2 * (pss[i] + 1)) @(negedge clk);
      end
    end
    check("idle_nev", evq.size(), 0);
    check("idle_pdata", u_if.p_data, 8'h00);

    // Single-cycle low pulse is rejected as a start glitch
    for (int i = 0; i < 3; i++) begin
      u_if.prescale = 5'(pss[i]);
      u_if.par_en   = 1'b0;
      @(negedge clk);
      evq.delete();
      c0 = cyc + 1;
      u_if.rx_in = 1'b0;
      @(negedge clk);
      u_if.rx_in = 1'b1;
      repeat (2 * (pss[i] + 1) + 4) @(negedge clk);
      check($sformatf("glitch%0d_nev", pss[i]), evq.size(), 1);
      if (evq.size() >= 1) begin
        check($sformatf("glitch%0d_kind", pss[i]), evq[0].kind, KGl);
        check($sformatf("glitch%0d_cyc", pss[i]), evq[0].cyc, c0 + pss[i] + Lat);
      end
    end

    foreach (frames[i]) run_frame(frames[i]);

    // Back-to-back frames: OUT costs one cycle before the second START
    u_if.prescale = 5'd15;
    u_if.par_en   = 1'b0;
    u_if.par_typ  = 1'b0;
    repeat (2) @(negedge clk);
    evq.delete();
    p  = 16;
    c0 = cyc + 1;
    send_frame(8'h3C, 1'b0, 1'b0, 15, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b0, 15, 1'b0, 1'b0);
    repeat (2 * p + 4) @(negedge clk);
    check("b2b_nev", evq.size(), 2);
    if (evq.size() >= 2) begin
      check("b2b0_kind", evq[0].kind, KDv);
      check("b2b0_cyc", evq[0].cyc, c0 + 10 * p + Lat);
      check("b2b0_data", evq[0].data, 8'h3C);
      check("b2b1_kind", evq[1].kind, KDv);
      check("b2b1_cyc", evq[1].cyc, c0 + 20 * p + 1 + Lat);
      check("b2b1_data", evq[1].data, 8'hC3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
